// File: rtl/mem_stage_ws.sv
// MEM pipeline stage: byte-addressable data memory with lane-correct sub-word
// stores, configurable wait states with a stall handshake, and misalignment faults.
module mem_stage_ws #(
    parameter int  NB_DATA       = 32,
    parameter int  N_REGS        = 32,
    parameter int  MEM_DEPTH     = 1024,
    parameter int  WAIT_STATES   = 0,
    parameter int  NB_WRB_CTRL   = 2,
    localparam int _NB_INDEX_REG = $clog2(N_REGS),
    localparam int NB_MADDR      = $clog2(MEM_DEPTH)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_pipe_enabled,
    input  logic [NB_DATA-1:0]       i_alu_result,
    input  logic [NB_DATA-1:0]       i_data_rt,
    input  logic [_NB_INDEX_REG-1:0] i_reg_dest,
    input  logic                     i_mem_rd,
    input  logic                     i_mem_wr,
    input  logic [1:0]               i_mem_size,
    input  logic                     i_sign_ext,
    input  logic [NB_WRB_CTRL-1:0]   i_control_wrb,
    input  logic [NB_DATA-1:0]       i_dbg_addr,
    output logic                     o_stall,
    output logic [NB_DATA-1:0]       o_alu_result,
    output logic [NB_DATA-1:0]       o_mem_data,
    output logic [_NB_INDEX_REG-1:0] o_reg_dest,
    output logic [NB_WRB_CTRL-1:0]   o_control_wrb,
    output logic                     o_fault,
    output logic [NB_DATA-1:0]       o_dbg_data
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic       HAS_WAIT = (WAIT_STATES > 0) ? 1'b1 : 1'b0;
    localparam logic [3:0] WS_M1    = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    function automatic logic size_fault(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   size_fault = 1'b0;
            2'b01:   size_fault = a[0];
            2'b10:   size_fault = (a != 2'b00);
            default: size_fault = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   byte_en = 4'b0001 << a;
            2'b01:   byte_en = 4'b0011 << {a[1], 1'b0};
            2'b10:   byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] rt);
        case (size)
            2'b00:   store_lanes = {4{rt[7:0]}};
            2'b01:   store_lanes = {2{rt[15:0]}};
            default: store_lanes = rt;
        endcase
    endfunction

    function automatic logic [31:0] load_align(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] a, input logic sext);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{a, 3'b000} +: 8];
        h = word[{a[1], 4'b0000} +: 16];
        case (size)
            2'b00:   load_align = {{24{sext & b[7]}}, b};
            2'b01:   load_align = {{16{sext & h[15]}}, h};
            2'b10:   load_align = word;
            default: load_align = 32'h0000_0000;
        endcase
    endfunction

    logic [NB_DATA-1:0] mem_q [MEM_DEPTH];

    state_t                   state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic [NB_DATA-1:0]       alu_q, alu_d;
    logic [NB_DATA-1:0]       data_q, data_d;
    logic [_NB_INDEX_REG-1:0] dest_q, dest_d;
    logic [NB_WRB_CTRL-1:0]   ctrl_q, ctrl_d;
    logic                     fault_q, fault_d;

    logic [NB_MADDR-1:0] widx_s;
    logic [1:0]          lane_s;
    logic                access_s;
    logic                fault_s;
    logic                valid_s;
    logic                stall_s;
    logic                complete_s;
    logic                we_s;
    logic [3:0]          be_s;
    logic [31:0]         wdata_s;
    logic [31:0]         rdata_s;
    logic                unused_s;

    assign widx_s     = i_alu_result[2 +: NB_MADDR];
    assign lane_s     = i_alu_result[1:0];
    assign access_s   = i_mem_rd | i_mem_wr;
    assign fault_s    = access_s & size_fault(i_mem_size, lane_s);
    assign valid_s    = access_s & ~fault_s;
    assign complete_s = i_pipe_enabled & ~stall_s;
    // Reset aborts any access in flight, so nothing may reach the array while it is held.
    assign we_s       = complete_s & i_mem_wr & ~fault_s & ~i_rst;
    assign be_s       = byte_en(i_mem_size, lane_s);
    assign wdata_s    = store_lanes(i_mem_size, i_data_rt);
    assign rdata_s    = mem_q[widx_s];
    assign unused_s   = ^{i_dbg_addr[NB_DATA-1:NB_MADDR], i_alu_result[NB_DATA-1:NB_MADDR+2]};

    // Wait-state sequencer: next state, counter and stall request.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (valid_s && HAS_WAIT) begin
                    stall_s = 1'b1;
                    if (i_pipe_enabled) begin
                        state_d = ST_WAIT;
                        cnt_d   = WS_M1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                stall_s = (cnt_q != 4'd0);
                if (i_pipe_enabled) begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Output capture on completion; stores report no load data.
    always_comb begin
        alu_d   = alu_q;
        data_d  = data_q;
        dest_d  = dest_q;
        ctrl_d  = ctrl_q;
        fault_d = fault_q;
        if (complete_s) begin
            alu_d   = i_alu_result;
            dest_d  = i_reg_dest;
            fault_d = fault_s;
            ctrl_d  = fault_s ? {NB_WRB_CTRL{1'b0}} : i_control_wrb;
            if (i_mem_rd && !i_mem_wr && !fault_s) begin
                data_d = load_align(rdata_s, i_mem_size, lane_s, i_sign_ext);
            end else begin
                data_d = {NB_DATA{1'b0}};
            end
        end else begin
            data_d = data_q;
        end
    end

    // Sequencer and pipeline output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            alu_q   <= {NB_DATA{1'b0}};
            data_q  <= {NB_DATA{1'b0}};
            dest_q  <= {_NB_INDEX_REG{1'b0}};
            ctrl_q  <= {NB_WRB_CTRL{1'b0}};
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            alu_q   <= alu_d;
            data_q  <= data_d;
            dest_q  <= dest_d;
            ctrl_q  <= ctrl_d;
            fault_q <= fault_d;
        end
    end

    // Byte-enabled data memory write; contents are deliberately not reset.
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we_s && be_s[b]) begin
                mem_q[widx_s][8*b +: 8] <= wdata_s[8*b +: 8];
            end
        end
    end

    assign o_stall       = stall_s & ~i_rst;
    assign o_alu_result  = alu_q;
    assign o_mem_data    = data_q;
    assign o_reg_dest    = dest_q;
    assign o_control_wrb = ctrl_q;
    assign o_fault       = fault_q;
    assign o_dbg_data    = mem_q[i_dbg_addr[NB_MADDR-1:0]];

endmodule

// File: tb/tb_mem_stage_ws.sv
// Bench for mem_stage_ws: single-cycle instance (lane stores, loads, faults, wrap)
// and a two-wait-state instance (stall timing, pipeline freeze, reset abort).
module tb_mem_stage_ws;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        sext;
        logic [31:0] addr;
        logic [31:0] rt;
        logic [4:0]  rdest;
        logic [1:0]  ctrl;
        logic        chk_data;
        logic [31:0] exp_data;
        logic        exp_fault;
        logic [31:0] dbg_idx;
        logic [31:0] exp_dbg;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_en;
    logic [31:0] alu_in, rt_in, dbg_addr;
    logic [4:0]  rdest_in;
    logic        mem_rd, mem_wr, sext;
    logic [1:0]  size, ctrl_in;

    logic        stall_0, fault_0, stall_w, fault_w;
    logic [31:0] alu_0, data_0, dbg_0, alu_w, data_w, dbg_w;
    logic [4:0]  rdest_0, rdest_w;
    logic [1:0]  ctrl_0, ctrl_w;

    int   n_checks = 0;
    int   n_pass   = 0;
    vec_t exp_q[$];
    vec_t tbl[21];

    always #5 clk = ~clk;

    mem_stage_ws #(.WAIT_STATES(0), .MEM_DEPTH(1024)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_pipe_enabled(pipe_en), .i_alu_result(alu_in),
        .i_data_rt(rt_in), .i_reg_dest(rdest_in), .i_mem_rd(mem_rd), .i_mem_wr(mem_wr),
        .i_mem_size(size), .i_sign_ext(sext), .i_control_wrb(ctrl_in), .i_dbg_addr(dbg_addr),
        .o_stall(stall_0), .o_alu_result(alu_0), .o_mem_data(data_0), .o_reg_dest(rdest_0),
        .o_control_wrb(ctrl_0), .o_fault(fault_0), .o_dbg_data(dbg_0)
    );

    mem_stage_ws #(.WAIT_STATES(2), .MEM_DEPTH(64)) dutw (
        .i_clk(clk), .i_rst(rst), .i_pipe_enabled(pipe_en), .i_alu_result(alu_in),
        .i_data_rt(rt_in), .i_reg_dest(rdest_in), .i_mem_rd(mem_rd), .i_mem_wr(mem_wr),
        .i_mem_size(size), .i_sign_ext(sext), .i_control_wrb(ctrl_in), .i_dbg_addr(dbg_addr),
        .o_stall(stall_w), .o_alu_result(alu_w), .o_mem_data(data_w), .o_reg_dest(rdest_w),
        .o_control_wrb(ctrl_w), .o_fault(fault_w), .o_dbg_data(dbg_w)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [1:0] sz,
                                input logic se, input logic [31:0] addr, input logic [31:0] rt,
                                input logic chk, input logic [31:0] ed, input logic ef,
                                input logic [31:0] di, input logic [31:0] edbg);
        vec_t v;
        v.rd = rd; v.wr = wr; v.size = sz; v.sext = se; v.addr = addr; v.rt = rt;
        v.rdest = 5'd7; v.ctrl = 2'b11; v.chk_data = chk; v.exp_data = ed;
        v.exp_fault = ef; v.dbg_idx = di; v.exp_dbg = edbg;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        mem_rd = v.rd; mem_wr = v.wr; size = v.size; sext = v.sext;
        alu_in = v.addr; rt_in = v.rt; rdest_in = v.rdest; ctrl_in = v.ctrl;
    endtask

    task automatic drive_idle();
        drive(mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0));
    endtask

    // Present one access, wait out its stall, then pop the scoreboard and compare.
    task automatic run_access(input vec_t v, input bit use_w, input string tag);
        vec_t e;
        int   stalls;
        int   ws;
        @(negedge clk);
        drive(v);
        exp_q.push_back(v);
        #1;
        stalls = 0;
        while ((use_w ? stall_w : stall_0) && stalls < 40) begin
            stalls++;
            @(negedge clk);
        end
        if (stalls >= 40) begin
            n_checks++;
            $display("FAIL %s_timeout: stall still high after %0d cycles, required release", tag, stalls);
        end
        @(posedge clk);
        #1;
        e  = exp_q.pop_front();
        ws = (use_w && (e.rd || e.wr) && !e.exp_fault) ? 2 : 0;
        check({tag, "_stalls"}, 32'(stalls), 32'(ws));
        check({tag, "_fault"}, 32'(use_w ? fault_w : fault_0), 32'(e.exp_fault));
        check({tag, "_ctrl"}, 32'(use_w ? ctrl_w : ctrl_0), e.exp_fault ? 32'h0 : 32'(e.ctrl));
        check({tag, "_rdest"}, 32'(use_w ? rdest_w : rdest_0), 32'(e.rdest));
        check({tag, "_alu"}, use_w ? alu_w : alu_0, e.addr);
        if (e.chk_data) begin
            check({tag, "_data"}, use_w ? data_w : data_0, e.exp_data);
        end
        dbg_addr = e.dbg_idx;
        #1;
        check({tag, "_dbg"}, use_w ? dbg_w : dbg_0, e.exp_dbg);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h40,   32'h11223344, 1'b0, 32'h0,        1'b0, 32'h10, 32'h11223344);
        tbl[1]  = mk(1'b0, 1'b1, 2'b00, 1'b0, 32'h41,   32'h000000AB, 1'b0, 32'h0,        1'b0, 32'h10, 32'h1122AB44);
        tbl[2]  = mk(1'b0, 1'b1, 2'b01, 1'b0, 32'h42,   32'h0000BEEF, 1'b0, 32'h0,        1'b0, 32'h10, 32'hBEEFAB44);
        tbl[3]  = mk(1'b1, 1'b0, 2'b00, 1'b1, 32'h41,   32'h0,        1'b1, 32'hFFFFFFAB, 1'b0, 32'h10, 32'hBEEFAB44);
        tbl[4]  = mk(1'b1, 1'b0, 2'b00, 1'b0, 32'h41,   32'h0,        1'b1, 32'h000000AB, 1'b0, 32'h10, 32'hBEEFAB44);
        tbl[5]  = mk(1'b1, 1'b0, 2'b01, 1'b1, 32'h42,   32'h0,        1'b1, 32'hFFFFBEEF, 1'b0, 32'h10, 32'hBEEFAB44);
        tbl[6]  = mk(1'b1, 1'b0, 2'b01, 1'b0, 32'h40,   32'h0,        1'b1, 32'h0000AB44, 1'b0, 32'h10, 32'hBEEFAB44);
        tbl[7]  = mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h40,   32'h0,        1'b1, 32'hBEEFAB44, 1'b0, 32'h10, 32'hBEEFAB44);
        tbl[8]  = mk(1'b1, 1'b0, 2'b01, 1'b1, 32'h43,   32'h0,        1'b1, 32'h0,        1'b1, 32'h10, 32'hBEEFAB44);
        tbl[9]  = mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h42,   32'hDEADBEEF, 1'b0, 32'h0,        1'b1, 32'h10, 32'hBEEFAB44);
        tbl[10] = mk(1'b1, 1'b0, 2'b11, 1'b0, 32'h40,   32'h0,        1'b1, 32'h0,        1'b1, 32'h10, 32'hBEEFAB44);
        tbl[11] = mk(1'b1, 1'b0, 2'b00, 1'b1, 32'h40,   32'h0,        1'b1, 32'h00000044, 1'b0, 32'h10, 32'hBEEFAB44);
        tbl[12] = mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h1008, 32'hCAFEF00D, 1'b0, 32'h0,        1'b0, 32'h2,  32'hCAFEF00D);
        tbl[13] = mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h08,   32'h0,        1'b1, 32'hCAFEF00D, 1'b0, 32'h2,  32'hCAFEF00D);
        tbl[14] = mk(1'b0, 1'b1, 2'b00, 1'b0, 32'h0B,   32'h00000080, 1'b0, 32'h0,        1'b0, 32'h2,  32'h80FEF00D);
        tbl[15] = mk(1'b1, 1'b0, 2'b00, 1'b1, 32'h0B,   32'h0,        1'b1, 32'hFFFFFF80, 1'b0, 32'h2,  32'h80FEF00D);
        tbl[16] = mk(1'b1, 1'b0, 2'b01, 1'b0, 32'h0A,   32'h0,        1'b1, 32'h000080FE, 1'b0, 32'h2,  32'h80FEF00D);
        tbl[17] = mk(1'b0, 1'b1, 2'b01, 1'b0, 32'h08,   32'h00001234, 1'b0, 32'h0,        1'b0, 32'h2,  32'h80FE1234);
        tbl[18] = mk(1'b0, 1'b0, 2'b11, 1'b0, 32'h12345678, 32'h0,    1'b1, 32'h0,        1'b0, 32'h2,  32'h80FE1234);
        tbl[19] = mk(1'b1, 1'b1, 2'b00, 1'b0, 32'h09,   32'h00000055, 1'b0, 32'h0,        1'b0, 32'h2,  32'h80FE5534);
        tbl[20] = mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h08,   32'h0,        1'b1, 32'h80FE5534, 1'b0, 32'h2,  32'h80FE5534);

        rst = 1'b1; pipe_en = 1'b1; dbg_addr = 32'h0;
        drive_idle();
        @(negedge clk);
        check("rst_alu_0", alu_0, 32'h0);       check("rst_data_0", data_0, 32'h0);
        check("rst_rdest_0", 32'(rdest_0), 32'h0); check("rst_ctrl_0", 32'(ctrl_0), 32'h0);
        check("rst_fault_0", 32'(fault_0), 32'h0); check("rst_stall_0", 32'(stall_0), 32'h0);
        check("rst_alu_w", alu_w, 32'h0);       check("rst_data_w", data_w, 32'h0);
        check("rst_rdest_w", 32'(rdest_w), 32'h0); check("rst_ctrl_w", 32'(ctrl_w), 32'h0);
        check("rst_fault_w", 32'(fault_w), 32'h0); check("rst_stall_w", 32'(stall_w), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            tbl[i].rdest = 5'(i + 1);
            tbl[i].ctrl  = (i % 2 == 1) ? 2'b11 : 2'b10;
            run_access(tbl[i], 1'b0, $sformatf("v%0d", i));
        end

        // Two-wait-state instance starts from a clean sequencer.
        @(negedge clk);
        drive_idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        run_access(mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0A0B0C0D, 1'b0, 32'h0, 1'b0, 32'h4, 32'h0A0B0C0D), 1'b1, "w_sw0");
        run_access(mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h14, 32'h55667788, 1'b0, 32'h0, 1'b0, 32'h5, 32'h55667788), 1'b1, "w_sw1");
        run_access(mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 1'b1, 32'h55667788, 1'b0, 32'h5, 32'h55667788), 1'b1, "w_lw1");

        // LW presented at T0 with the pipeline frozen for three cycles during T1.
        @(negedge clk);
        drive(mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0, 1'b0, 32'h4, 32'h0));
        #1;
        check("ws_t0_stall", 32'(stall_w), 32'h1);
        @(negedge clk);
        check("ws_t1_stall", 32'(stall_w), 32'h1);
        pipe_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("ws_frozen%0d_stall", k), 32'(stall_w), 32'h1);
            check($sformatf("ws_frozen%0d_data", k), data_w, 32'h55667788);
        end
        pipe_en = 1'b1;
        @(negedge clk);
        check("ws_t2_stall", 32'(stall_w), 32'h0);
        check("ws_t2_data_old", data_w, 32'h55667788);
        @(negedge clk);
        check("ws_done_data", data_w, 32'h0A0B0C0D);
        check("ws_done_alu", alu_w, 32'h10);
        drive_idle();

        run_access(mk(1'b1, 1'b0, 2'b01, 1'b1, 32'h11, 32'h0, 1'b1, 32'h0, 1'b1, 32'h4, 32'h0A0B0C0D), 1'b1, "w_fault");
        run_access(mk(1'b1, 1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 1'b1, 32'h0000000B, 1'b0, 32'h4, 32'h0A0B0C0D), 1'b1, "w_lbu");

        // Reset in the middle of a store's wait states.
        @(negedge clk);
        drive(mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0, 32'h4, 32'h0));
        @(negedge clk);
        check("rstw_pre_stall", 32'(stall_w), 32'h1);
        rst = 1'b1;
        #1;
        check("rstw_alu", alu_w, 32'h0);
        check("rstw_data", data_w, 32'h0);
        check("rstw_rdest", 32'(rdest_w), 32'h0);
        check("rstw_ctrl", 32'(ctrl_w), 32'h0);
        check("rstw_fault", 32'(fault_w), 32'h0);
        check("rstw_stall", 32'(stall_w), 32'h0);
        @(negedge clk);
        drive_idle();
        rst = 1'b0;
        dbg_addr = 32'h4;
        #1;
        check("rstw_mem_kept", dbg_w, 32'h0A0B0C0D);

        run_access(mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0A0B0C0D, 1'b0, 32'h4, 32'h0A0B0C0D), 1'b1, "w_after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
